// File: rtl/dff_pipeline.sv
// Elastic WIDTH-bit, DEPTH-stage register pipeline with ready/valid handshake,
// bubble collapsing, global enable, synchronous flush and an occupancy count.
module dff_pipeline #(
    parameter int              WIDTH     = 8,
    parameter int              DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                       Clk,
    input  logic                       Rst,
    input  logic                       En,
    input  logic                       Flush,
    input  logic                       In_valid,
    output logic                       In_ready,
    input  logic [WIDTH-1:0]           D,
    output logic                       Out_valid,
    input  logic                       Out_ready,
    output logic [WIDTH-1:0]           Q,
    output logic [WIDTH-1:0]           Qn,
    output logic [$clog2(DEPTH+1)-1:0] Occupancy
);

    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] data_q [DEPTH];
    logic [WIDTH-1:0] data_d [DEPTH];
    logic [DEPTH-1:0] v_q;
    logic [DEPTH-1:0] v_d;
    logic [DEPTH-1:0] rdy;
    logic [OCC_W-1:0] occ_cnt;

    // A stage is ready when it, or any stage downstream of it, holds a bubble,
    // or when the consumer is taking the last word.
    always_comb begin
        logic bubble;
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        rdy    = '0;
        bubble = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            bubble = bubble | ~v_q[i];
            rdy[i] = Out_ready | bubble;
        end
    end

    assign In_ready  = En & ~Flush & rdy[0];
    assign Out_valid = En & v_q[DEPTH-1];
    assign Q         = data_q[DEPTH-1];
    assign Qn        = ~data_q[DEPTH-1];

    // Data only moves with a valid word, so an empty output stage keeps Q stable.
    always_comb begin
        data_d = data_q;
        v_d    = v_q;
        if (Flush) begin
            v_d = '0;
        end else if (En) begin
            if (rdy[0]) begin
                v_d[0] = In_valid;
                if (In_valid) data_d[0] = D;
            end
            for (int i = 1; i < DEPTH; i++) begin
                if (rdy[i]) begin
                    v_d[i] = v_q[i-1];
                    if (v_q[i-1]) data_d[i] = data_q[i-1];
                end
            end
        end
    end

    // NOTE: state uses non-blocking assignments so every stage samples pre-edge values.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            v_q <= '0;
            // NOTE: the data array is reset deliberately; Q must show RESET_VAL after reset.
            for (int i = 0; i < DEPTH; i++) data_q[i] <= RESET_VAL;
        end else begin
            v_q    <= v_d;
            data_q <= data_d;
        end
    end

    always_comb begin
        occ_cnt = '0;
        for (int i = 0; i < DEPTH; i++) occ_cnt = occ_cnt + OCC_W'(v_q[i]);
    end

    assign Occupancy = occ_cnt;

endmodule

// File: tb/tb_dff_pipeline.sv
// Scoreboard bench for dff_pipeline: directed scenarios followed by random
// traffic checked against a word-queue model of the pipeline contents.
module tb_dff_pipeline;

    localparam int         WIDTH     = 8;
    localparam int         DEPTH     = 4;
    localparam logic [7:0] RESET_VAL = 8'h00;

    logic             Clk;
    logic             Rst;
    logic             En;
    logic             Flush;
    logic             In_valid;
    logic             In_ready;
    logic [WIDTH-1:0] D;
    logic             Out_valid;
    logic             Out_ready;
    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] Qn;
    logic [2:0]       Occupancy;

    dff_pipeline #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VAL(RESET_VAL)) dut (
        .Clk(Clk), .Rst(Rst), .En(En), .Flush(Flush),
        .In_valid(In_valid), .In_ready(In_ready), .D(D),
        .Out_valid(Out_valid), .Out_ready(Out_ready),
        .Q(Q), .Qn(Qn), .Occupancy(Occupancy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int errors = 0;
    int checks = 0;

    // Model: words accepted but not yet delivered, oldest first.
    logic [7:0] exp_q [$];
    int         occ_model    = 0;
    logic       exp_in_ready = 1'b0;
    logic [7:0] q_model      = RESET_VAL;
    logic       q_known      = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs after the rising edge, record any word the model
    // says is accepted, then return mid-cycle so the caller can sample outputs.
    task automatic step(input logic iv, input logic [7:0] d, input logic ordy,
                        input logic en, input logic fl, input logic rst);
        @(posedge Clk);
        #1;
        In_valid  = iv;
        D         = d;
        Out_ready = ordy;
        En        = en;
        Flush     = fl;
        Rst       = rst;
        exp_in_ready = en && !fl && ((occ_model < DEPTH) || ordy);
        if (iv && exp_in_ready) exp_q.push_back(d);
        @(negedge Clk);
        #1;
    endtask

    // Monitor: compares whatever the DUT presents against the model each cycle.
    always @(negedge Clk) begin : monitor
        logic [7:0] exp_word;
        logic [7:0] exp_inv;
        logic       in_x;
        logic       out_x;
        check("in_ready", In_ready, exp_in_ready);
        check("occupancy", Occupancy, occ_model);
        if (!En) check("out_valid_frozen", Out_valid, 1'b0);
        out_x = 1'b0;
        if (occ_model == 0) begin
            check("out_valid_empty", Out_valid, 1'b0);
        end else if (Out_valid) begin
            exp_word = exp_q[0];
            exp_inv  = ~exp_word;
            check("q_data", Q, exp_word);
            check("qn_data", Qn, exp_inv);
            q_model = exp_word;
            q_known = 1'b1;
            if (Out_ready) begin
                void'(exp_q.pop_front());
                out_x = 1'b1;
            end
        end else if (En && q_known) begin
            exp_inv = ~q_model;
            check("q_hold", Q, q_model);
            check("qn_hold", Qn, exp_inv);
        end
        in_x = In_valid && exp_in_ready;
        if (Rst) begin
            occ_model = 0;
            exp_q.delete();
            q_model = RESET_VAL;
            q_known = 1'b1;
        end else if (Flush) begin
            occ_model = 0;
            exp_q.delete();
            if (!En) q_known = 1'b0;
        end else begin
            occ_model = occ_model + (in_x ? 1 : 0) - (out_x ? 1 : 0);
        end
    end

    logic [7:0] stream [3] = '{8'h11, 8'h22, 8'h33};
    logic [7:0] fill   [5] = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};

    initial begin
        Rst = 1'b1; En = 1'b1; Flush = 1'b0;
        In_valid = 1'b0; D = '0; Out_ready = 1'b0;

        // Reset held for two edges.
        step(0, 8'h00, 0, 1, 0, 1);
        step(0, 8'h00, 0, 1, 0, 1);
        check("rst_out_valid", Out_valid, 1'b0);
        check("rst_q", Q, 8'h00);
        check("rst_qn", Qn, 8'hFF);
        check("rst_occ", Occupancy, 3'd0);
        check("rst_in_ready", In_ready, 1'b1);

        // Streaming: three words back to back, visible DEPTH-1 edges later.
        for (int j = 0; j < 8; j++) begin
            step(j < 3, (j < 3) ? stream[j] : 8'h00, 1, 1, 0, 0);
            if (j == 3) check("stream_no_early", Out_valid, 1'b0);
            if (j >= 4 && j <= 6) begin
                check("stream_valid", Out_valid, 1'b1);
                check("stream_q", Q, stream[j-4]);
            end
            if (j == 7) begin
                check("stream_idle", Out_valid, 1'b0);
                check("stream_q_held", Q, 8'h33);
            end
        end

        // Backpressure fill then drain with simultaneous in/out transfer.
        for (int j = 0; j < 4; j++) step(1, fill[j], 0, 1, 0, 0);
        step(1, fill[4], 0, 1, 0, 0);
        check("full_in_ready", In_ready, 1'b0);
        check("full_occ", Occupancy, 3'd4);
        step(1, fill[4], 1, 1, 0, 0);
        check("full_pass_in_ready", In_ready, 1'b1);
        check("full_pass_q", Q, 8'hA1);
        for (int j = 1; j < 5; j++) begin
            step(0, 8'h00, 1, 1, 0, 0);
            check("drain_occ_or_q", Q, fill[j]);
            if (j == 1) check("full_occ_stays", Occupancy, 3'd4);
        end
        step(0, 8'h00, 1, 1, 0, 0);
        check("drain_empty", Out_valid, 1'b0);

        // Bubble collapse under backpressure.
        step(1, 8'h01, 0, 1, 0, 0);
        step(0, 8'h00, 0, 1, 0, 0);
        step(0, 8'h00, 0, 1, 0, 0);
        step(1, 8'h02, 0, 1, 0, 0);
        step(0, 8'h00, 0, 1, 0, 0);
        step(0, 8'h00, 0, 1, 0, 0);
        step(0, 8'h00, 1, 1, 0, 0);
        check("bubble_occ", Occupancy, 3'd2);
        check("bubble_first", Q, 8'h01);
        check("bubble_first_v", Out_valid, 1'b1);
        step(0, 8'h00, 1, 1, 0, 0);
        check("bubble_second", Q, 8'h02);
        check("bubble_second_v", Out_valid, 1'b1);
        step(0, 8'h00, 1, 1, 0, 0);
        check("bubble_done", Out_valid, 1'b0);

        // Flush with an offered word that must be refused.
        step(1, 8'hB1, 0, 1, 0, 0);
        step(1, 8'hB2, 0, 1, 0, 0);
        step(1, 8'hB3, 0, 1, 0, 0);
        step(1, 8'hEE, 0, 1, 1, 0);
        check("flush_occ_before", Occupancy, 3'd3);
        check("flush_in_ready", In_ready, 1'b0);
        step(0, 8'h00, 1, 1, 0, 0);
        check("flush_occ_after", Occupancy, 3'd0);
        check("flush_out_valid", Out_valid, 1'b0);
        for (int j = 0; j < 5; j++) begin
            step(0, 8'h00, 1, 1, 0, 0);
            check("flush_no_ghost", Out_valid, 1'b0);
        end

        // Freeze with En=0, then reset mid-operation.
        step(1, 8'hC1, 0, 1, 0, 0);
        step(1, 8'hC2, 0, 1, 0, 0);
        step(0, 8'h00, 0, 1, 0, 0);
        step(0, 8'h00, 0, 1, 0, 0);
        step(0, 8'h00, 0, 1, 0, 0);
        check("freeze_pre_occ", Occupancy, 3'd2);
        check("freeze_pre_q", Q, 8'hC1);
        for (int j = 0; j < 5; j++) begin
            step(1, 8'hDD, 1, 0, 0, 0);
            check("freeze_occ", Occupancy, 3'd2);
            check("freeze_q", Q, 8'hC1);
            check("freeze_qn", Qn, 8'h3E);
            check("freeze_out_valid", Out_valid, 1'b0);
            check("freeze_in_ready", In_ready, 1'b0);
        end
        step(0, 8'h00, 0, 1, 0, 1);
        step(0, 8'h00, 0, 1, 0, 0);
        check("midrst_occ", Occupancy, 3'd0);
        check("midrst_q", Q, RESET_VAL);
        check("midrst_qn", Qn, 8'hFF);
        check("midrst_out_valid", Out_valid, 1'b0);
        check("midrst_in_ready", In_ready, 1'b1);

        // Random traffic; backpressure density changes every 250 cycles.
        for (int j = 0; j < 2000; j++) begin
            int ordy_pct;
            ordy_pct = ((j / 250) % 2 == 0) ? 8 : 3;
            step($urandom_range(0, 3) != 0, 8'($urandom),
                 $urandom_range(0, 9) < ordy_pct,
                 $urandom_range(0, 9) != 0,
                 $urandom_range(0, 59) == 0,
                 $urandom_range(0, 299) == 0);
        end

        for (int j = 0; j < DEPTH + 6; j++) step(0, 8'h00, 1, 1, 0, 0);
        check("final_words_delivered", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
